// File: rtl/adc_scan_pkg.sv
// Shared types, widths and channel-search helper for the ADC scan sequencer.
package adc_scan_pkg;

    localparam int ADC_CH_W   = 3;
    localparam int ADC_NCH    = 8;
    localparam int ADC_DATA_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_START,
        ST_BUSY,
        ST_NEXT
    } scan_state_e;

    // Lowest set bit of mask at position >= from; 0 when none (callers guarantee one exists).
    function automatic logic [ADC_CH_W-1:0] lowest_set_from(
        input logic [ADC_NCH-1:0]  mask,
        input logic [ADC_CH_W-1:0] from
    );
        logic [ADC_CH_W-1:0] ch;
        logic                found;
        ch    = '0;
        found = 1'b0;
        for (int i = 0; i < ADC_NCH; i++) begin
            if (!found && mask[i] && (i >= int'(from))) begin
                ch    = ADC_CH_W'(i);
                found = 1'b1;
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/adc_scan_timer.sv
// Free-running sample-period counter; tick marks the terminal count and the count wraps.
module adc_scan_timer #(
    parameter int SAMPLE_PERIOD = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CNT_W'(SAMPLE_PERIOD - 1));
        cnt_d = '0;
        if (en && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_scan_seq.sv
// Periodic multi-channel scan scheduler in front of the ADC128S022 SPI controller.
// state    | meaning
// IDLE     | waiting for a period tick
// SEL      | pick next channel from the latched mask
// START    | one-cycle start pulse to the SPI controller
// BUSY     | waiting for adc_done or the conversion timeout
// NEXT     | retire serviced channel, loop or finish the scan
module adc_scan_seq
    import adc_scan_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 50000,
    parameter int TIMEOUT       = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADC_NCH-1:0]    ch_mask,
    input  logic                  clr_flags,
    output logic                  adc_start,
    output logic [ADC_CH_W-1:0]   adc_channel,
    input  logic                  adc_done,
    input  logic [ADC_DATA_W-1:0] adc_data,
    output logic                  res_valid,
    output logic [ADC_CH_W-1:0]   res_channel,
    output logic [ADC_DATA_W-1:0] res_data,
    output logic                  scan_done,
    input  logic [ADC_CH_W-1:0]   rd_ch,
    output logic [ADC_DATA_W-1:0] rd_data,
    output logic                  overrun,
    output logic                  err_timeout
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    scan_state_e                          state_q, state_d;
    logic [ADC_NCH-1:0]                   scan_mask_q, scan_mask_d;
    logic [ADC_CH_W-1:0]                  idx_q, idx_d;
    logic [ADC_CH_W-1:0]                  ch_q, ch_d;
    logic [TO_W-1:0]                      to_cnt_q, to_cnt_d;
    logic                                 res_valid_q, res_valid_d;
    logic [ADC_CH_W-1:0]                  res_channel_q, res_channel_d;
    logic [ADC_DATA_W-1:0]                res_data_q, res_data_d;
    logic [ADC_NCH-1:0][ADC_DATA_W-1:0]   regfile_q, regfile_d;
    logic                                 overrun_q, overrun_d;
    logic                                 err_q, err_d;
    logic                                 tick;
    logic                                 err_set;

    adc_scan_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    always_comb begin
        state_d       = state_q;
        scan_mask_d   = scan_mask_q;
        idx_d         = idx_q;
        ch_d          = ch_q;
        to_cnt_d      = to_cnt_q;
        res_valid_d   = 1'b0;
        res_channel_d = res_channel_q;
        res_data_d    = res_data_q;
        regfile_d     = regfile_q;
        err_set       = 1'b0;
        scan_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick && (|ch_mask)) begin
                    scan_mask_d = ch_mask;
                    idx_d       = '0;
                    state_d     = ST_SEL;
                end
            end
            ST_SEL: begin
                ch_d    = lowest_set_from(scan_mask_q, idx_q);
                state_d = ST_START;
            end
            ST_START: begin
                to_cnt_d = '0;
                state_d  = ST_BUSY;
            end
            ST_BUSY: begin
                // A done arriving on the timeout cycle is still accepted.
                if (adc_done) begin
                    res_data_d      = adc_data;
                    res_channel_d   = ch_q;
                    res_valid_d     = 1'b1;
                    regfile_d[ch_q] = adc_data;
                    state_d         = ST_NEXT;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_NEXT: begin
                scan_mask_d = scan_mask_q & ~(ADC_NCH'(1) << ch_q);
                if (|scan_mask_d) begin
                    idx_d   = ch_q + ADC_CH_W'(1);
                    state_d = ST_SEL;
                end else begin
                    scan_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        overrun_d = (tick && (state_q != ST_IDLE)) ? 1'b1 : (clr_flags ? 1'b0 : overrun_q);
        err_d     = err_set ? 1'b1 : (clr_flags ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            scan_mask_q   <= '0;
            idx_q         <= '0;
            ch_q          <= '0;
            to_cnt_q      <= '0;
            res_valid_q   <= 1'b0;
            res_channel_q <= '0;
            res_data_q    <= '0;
            regfile_q     <= '0;
            overrun_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            scan_mask_q   <= scan_mask_d;
            idx_q         <= idx_d;
            ch_q          <= ch_d;
            to_cnt_q      <= to_cnt_d;
            res_valid_q   <= res_valid_d;
            res_channel_q <= res_channel_d;
            res_data_q    <= res_data_d;
            regfile_q     <= regfile_d;
            overrun_q     <= overrun_d;
            err_q         <= err_d;
        end
    end

    assign adc_start   = (state_q == ST_START);
    assign adc_channel = ch_q;
    assign res_valid   = res_valid_q;
    assign res_channel = res_channel_q;
    assign res_data    = res_data_q;
    assign rd_data     = regfile_q[rd_ch];
    assign overrun     = overrun_q;
    assign err_timeout = err_q;

endmodule
